// File: rtl/banco_registradores.sv
// 32 x 32-bit MIPS register file: two combinational operand ports with same-cycle
// write forwarding, one ungated debug port, and a committed-write counter.
module banco_registradores #(
    parameter int unsigned          DATA_W  = 32,
    parameter int unsigned          NREGS   = 32,
    parameter logic [DATA_W-1:0]    SP_INIT = DATA_W'(1023),
    parameter bit                   FORWARD = 1'b1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [$clog2(NREGS)-1:0]    rs_addr,
    input  logic [$clog2(NREGS)-1:0]    rt_addr,
    input  logic                        write_en,
    input  logic [$clog2(NREGS)-1:0]    rd_addr,
    input  logic [DATA_W-1:0]           write_data,
    input  logic [$clog2(NREGS)-1:0]    dbg_addr,
    output logic [DATA_W-1:0]           data1,
    output logic [DATA_W-1:0]           data2,
    output logic [DATA_W-1:0]           dbg_data,
    output logic [15:0]                 write_count
);

    localparam int unsigned AW     = $clog2(NREGS);
    localparam int unsigned CW     = 16;
    localparam int unsigned SP_IDX = 29;

    logic [DATA_W-1:0] regs [NREGS];
    logic              commit;

    // Reset has priority over any write presented in the same cycle.
    assign commit = write_en && enable && !reset && (rd_addr != AW'(0));

    // Storage and write counter; every entry is explicitly reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
            write_count <= '0;
        end else if (commit) begin
            regs[rd_addr] <= write_data;
            write_count   <= write_count + CW'(1);
        end
    end

    // Operand A: gated by enable, $zero hardwired, optional write forwarding.
    always_comb begin
        data1 = '0;
        if (enable && (rs_addr != AW'(0))) begin
            if (FORWARD && commit && (rs_addr == rd_addr)) begin
                data1 = write_data;
            end else begin
                data1 = regs[rs_addr];
            end
        end
    end

    // Operand B: same rules on rt_addr.
    always_comb begin
        data2 = '0;
        if (enable && (rt_addr != AW'(0))) begin
            if (FORWARD && commit && (rt_addr == rd_addr)) begin
                data2 = write_data;
            end else begin
                data2 = regs[rt_addr];
            end
        end
    end

    // Display port sees committed state only.
    always_comb begin
        dbg_data = '0;
        if (dbg_addr != AW'(0)) begin
            dbg_data = regs[dbg_addr];
        end
    end

endmodule

// File: tb/tb_banco_registradores.sv
// Directed bench for banco_registradores: stimulus queues expected outputs, a
// negedge monitor drains the queue and compares against the live DUT outputs.
module tb_banco_registradores;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        write_en;
    logic [4:0]  rd_addr;
    logic [31:0] write_data;
    logic [4:0]  dbg_addr;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] dbg_data;
    logic [15:0] write_count;

    typedef struct {
        string       name;
        int          sel;   // 0 data1, 1 data2, 2 dbg_data, 3 write_count
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   stim_done = 0;

    banco_registradores dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .write_en    (write_en),
        .rd_addr     (rd_addr),
        .write_data  (write_data),
        .dbg_addr    (dbg_addr),
        .data1       (data1),
        .data2       (data2),
        .dbg_data    (dbg_data),
        .write_count (write_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void want(input string n, input int s, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.sel  = s;
        e.val  = v;
        q.push_back(e);
    endfunction

    // Apply one cycle of inputs just after a rising edge.
    task automatic drive(input logic r, input logic en, input logic we,
                         input logic [4:0] rd, input logic [31:0] wd,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] dbg);
        @(posedge clock);
        #1;
        reset      = r;
        enable     = en;
        write_en   = we;
        rd_addr    = rd;
        write_data = wd;
        rs_addr    = rs;
        rt_addr    = rt;
        dbg_addr   = dbg;
    endtask

    // Monitor: outputs are stable by the falling edge; drain all pending checks.
    always @(negedge clock) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [31:0] got;
            e = q.pop_front();
            case (e.sel)
                0:       got = data1;
                1:       got = data2;
                2:       got = dbg_data;
                default: got = {16'h0, write_count};
            endcase
            total++;
            if (got !== e.val) begin
                bad++;
                $display("FAIL %s: got=%h exp=%h", e.name, got, e.val);
            end
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b0; write_en = 1'b0; rd_addr = '0;
        write_data = '0; rs_addr = '0; rt_addr = '0; dbg_addr = '0;

        // Reset, then sweep the debug port.
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            drive(0, 1, 0, 0, 0, 29, 0, 5'(i));
            want($sformatf("reset_dbg%0d", i), 2, (i == 29) ? 32'd1023 : 32'd0);
            if (i == 0) begin
                want("reset_count", 3, 32'd0);
                want("reset_sp_data1", 0, 32'd1023);
                want("reset_zero_data2", 1, 32'd0);
            end
        end

        // Write reg5, forwarded in the same cycle, visible the next.
        drive(0, 1, 1, 5, 32'hDEADBEEF, 5, 0, 5);
        want("w5_fwd_data1", 0, 32'hDEADBEEF);
        want("w5_pre_dbg", 2, 32'd0);
        want("w5_pre_count", 3, 32'd0);
        drive(0, 1, 0, 0, 0, 5, 5, 5);
        want("r5_data1", 0, 32'hDEADBEEF);
        want("r5_data2", 1, 32'hDEADBEEF);
        want("r5_dbg", 2, 32'hDEADBEEF);
        want("r5_count", 3, 32'd1);

        // Write to $zero is ignored.
        drive(0, 1, 1, 0, 32'h12345678, 0, 0, 0);
        want("w0_data1", 0, 32'd0);
        want("w0_data2", 1, 32'd0);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        want("r0_data1", 0, 32'd0);
        want("r0_dbg", 2, 32'd0);
        want("r0_count", 3, 32'd1);

        // Forwarding on both ports; debug port not forwarded.
        drive(0, 1, 1, 7, 32'hA5A5A5A5, 7, 7, 7);
        want("fwd7_data1", 0, 32'hA5A5A5A5);
        want("fwd7_data2", 1, 32'hA5A5A5A5);
        want("fwd7_dbg_nofwd", 2, 32'd0);
        drive(0, 1, 0, 0, 0, 7, 5, 7);
        want("r7_data1", 0, 32'hA5A5A5A5);
        want("r7_data2", 1, 32'hDEADBEEF);
        want("r7_dbg", 2, 32'hA5A5A5A5);
        want("r7_count", 3, 32'd2);

        // Forward only the matching port.
        drive(0, 1, 1, 9, 32'h0000_0042, 10, 9, 9);
        want("fwd9_data1_nomatch", 0, 32'd0);
        want("fwd9_data2", 1, 32'h0000_0042);

        // enable=0 blocks writes and zeroes operands; debug still live.
        drive(0, 0, 1, 3, 32'd99, 5, 7, 3);
        want("dis_data1", 0, 32'd0);
        want("dis_data2", 1, 32'd0);
        want("dis_dbg3", 2, 32'd0);
        want("dis_count", 3, 32'd3);
        drive(0, 0, 0, 0, 0, 5, 7, 5);
        want("dis_dbg5", 2, 32'hDEADBEEF);
        want("dis_data1b", 0, 32'd0);
        drive(0, 1, 0, 0, 0, 3, 9, 3);
        want("after_dis_r3", 0, 32'd0);
        want("after_dis_r9", 1, 32'h0000_0042);
        want("after_dis_count", 3, 32'd3);

        // Reset beats a simultaneous write; no forwarding during reset.
        drive(1, 1, 1, 4, 32'd7, 4, 0, 4);
        want("rst_w_data1", 0, 32'd0);
        drive(0, 1, 0, 0, 0, 29, 5, 4);
        want("rst_w_dbg4", 2, 32'd0);
        want("rst_w_count", 3, 32'd0);
        want("rst_w_sp", 0, 32'd1023);
        want("rst_w_r5", 1, 32'd0);

        // Drive the counter to FFFF, then one more commit wraps it.
        for (int i = 0; i < 65535; i++) begin
            drive(0, 1, 1, 1, 32'(i), 0, 0, 0);
        end
        drive(0, 1, 0, 0, 0, 0, 0, 1);
        want("pre_wrap_count", 3, 32'h0000_FFFF);
        want("pre_wrap_dbg1", 2, 32'd65534);
        drive(0, 1, 1, 2, 32'd1, 0, 2, 2);
        want("wrap_fwd_data2", 1, 32'd1);
        want("wrap_pre_count", 3, 32'h0000_FFFF);
        drive(0, 1, 0, 0, 0, 0, 0, 2);
        want("wrap_count", 3, 32'd0);
        want("wrap_dbg2", 2, 32'd1);

        stim_done = 1;
    end

    // Bounded drain of the scoreboard, then summary.
    initial begin
        int cycles;
        cycles = 0;
        while (!stim_done && cycles < 90000) begin
            @(posedge clock);
            cycles++;
        end
        if (!stim_done) begin
            total++;
            bad++;
            $display("FAIL stim_timeout: got=%0d cycles exp=stimulus complete", cycles);
        end
        cycles = 0;
        while (q.size() > 0 && cycles < 10) begin
            @(posedge clock);
            cycles++;
        end
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got=%0d pending exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
